// File: rtl/score_accum_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score_accum_if : card handshake between the dealer and the score block    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface score_accum_if #(
  parameter int NUM_HANDS = 2
) ();
  localparam int HAND_W = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;

  logic              card_valid;
  logic              card_ready;
  logic [HAND_W-1:0] card_hand;
  logic [3:0]        card_value;

  modport master (output card_valid, card_hand, card_value, input card_ready);
  modport slave  (input card_valid, card_hand, card_value, output card_ready);
endinterface
`default_nettype wire

// File: rtl/score_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score_accum : sequential multi-hand Baccarat scorer with round resolution |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module score_accum #(
  parameter int  NUM_HANDS = 2,
  parameter int  MAX_CARDS = 3,
  localparam int HAND_W    = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int CNT_W     = $clog2(MAX_CARDS + 1)
) (
  input  logic                         slow_clock,
  input  logic                         reset,
  input  logic                         clear,
  score_accum_if.slave                 card,
  input  logic                         finalize,
  output logic [4*NUM_HANDS-1:0]       score,
  output logic [CNT_W*NUM_HANDS-1:0]   card_count,
  output logic [NUM_HANDS-1:0]         natural,
  output logic                         result_valid,
  output logic [HAND_W-1:0]            winner,
  output logic                         tie
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEAL    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [3:0]        hand_score [NUM_HANDS];
  logic [CNT_W-1:0]  hand_count [NUM_HANDS];
  logic [HAND_W-1:0] winner_hold;
  logic              tie_hold;

  logic              open;
  logic              hand_ok;
  logic              accept;
  logic [CNT_W-1:0]  sel_count;
  logic [3:0]        sel_score;
  logic [3:0]        points;
  logic [4:0]        sum;
  logic [4:0]        sum_m10;
  logic [3:0]        wrapped;

  logic [3:0]        max_score;
  logic [HAND_W-1:0] best;
  logic              best_tie;
  logic              found;

  // Select the addressed hand without indexing past NUM_HANDS.
  always_comb begin
    sel_count = '0;
    sel_score = '0;
    for (int i = 0; i < NUM_HANDS; i++) begin
      if (card.card_hand == HAND_W'(i)) begin
        sel_count = hand_count[i];
        sel_score = hand_score[i];
      end
    end
  end

  assign open    = (state == IDLE) || (state == DEAL);
  assign hand_ok = {1'b0, card.card_hand} < (HAND_W + 1)'(NUM_HANDS);

  assign card.card_ready = open && !clear && !reset && hand_ok
                           && (sel_count < CNT_W'(MAX_CARDS));
  assign accept          = card.card_valid && card.card_ready;

  assign points  = (card.card_value >= 4'd10) ? 4'd0 : card.card_value;
  assign sum     = {1'b0, sel_score} + {1'b0, points};
  assign sum_m10 = sum - 5'd10;
  assign wrapped = (sum >= 5'd10) ? sum_m10[3:0] : sum[3:0];

  // Resolution: lowest-index hand at the maximum wins; any later hand at max is a tie.
  always_comb begin
    max_score = '0;
    best      = '0;
    best_tie  = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < NUM_HANDS; i++) begin
      if (hand_score[i] > max_score) max_score = hand_score[i];
    end
    for (int i = 0; i < NUM_HANDS; i++) begin
      if (hand_score[i] == max_score) begin
        if (found) begin
          best_tie = 1'b1;
        end else begin
          best  = HAND_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset || clear) begin
      for (int i = 0; i < NUM_HANDS; i++) begin
        hand_score[i] <= '0;
        hand_count[i] <= '0;
      end
      winner_hold <= '0;
      tie_hold    <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM_HANDS; i++) begin
          if (card.card_hand == HAND_W'(i)) begin
            hand_score[i] <= wrapped;
            hand_count[i] <= hand_count[i] + CNT_W'(1);
          end
        end
      end
      if (state == RESOLVE) begin
        winner_hold <= best;
        tie_hold    <= best_tie;
      end
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (finalize) state_next = RESOLVE;
                 else if (accept) state_next = DEAL;
        DEAL:    if (finalize) state_next = RESOLVE;
        RESOLVE: state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign result_valid = (state == DONE);
  assign winner       = result_valid ? winner_hold : '0;
  assign tie          = result_valid && tie_hold;

  for (genvar i = 0; i < NUM_HANDS; i++) begin : g_out
    assign score[4*i +: 4]              = hand_score[i];
    assign card_count[CNT_W*i +: CNT_W] = hand_count[i];
    assign natural[i] = (hand_count[i] == CNT_W'(2)) && (hand_score[i] >= 4'd8);
  end

endmodule
`default_nettype wire

// File: tb/tb_score_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_score_accum : scoreboard bench for two score_accum configurations      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_score_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  score_accum_if #(.NUM_HANDS(2)) if_a ();
  score_accum_if #(.NUM_HANDS(4)) if_b ();

  logic        rst_a, clr_a, fin_a, rst_b, clr_b, fin_b;
  logic [7:0]  score_a;
  logic [3:0]  cnt_a;
  logic [1:0]  nat_a;
  logic        rv_a, tie_a;
  logic [0:0]  win_a;
  logic [15:0] score_b;
  logic [11:0] cnt_b;
  logic [3:0]  nat_b;
  logic        rv_b, tie_b;
  logic [1:0]  win_b;

  score_accum #(.NUM_HANDS(2), .MAX_CARDS(3)) dut_a (
    .slow_clock(clk), .reset(rst_a), .clear(clr_a), .card(if_a), .finalize(fin_a),
    .score(score_a), .card_count(cnt_a), .natural(nat_a),
    .result_valid(rv_a), .winner(win_a), .tie(tie_a));

  score_accum #(.NUM_HANDS(4), .MAX_CARDS(5)) dut_b (
    .slow_clock(clk), .reset(rst_b), .clear(clr_b), .card(if_b), .finalize(fin_b),
    .score(score_b), .card_count(cnt_b), .natural(nat_b),
    .result_valid(rv_b), .winner(win_b), .tie(tie_b));

  typedef struct {
    int winner;
    int tie;
  } res_t;

  res_t q_a[$];
  res_t q_b[$];
  int   m_score [2][4];
  int   m_cnt   [2][4];
  int   m_phase [2];      // 0 taking cards, 1 resolving, 2 result shown
  int   total = 0;
  int   bad   = 0;

  function automatic int nh(int s); return (s == 0) ? 2 : 4; endfunction
  function automatic int mc(int s); return (s == 0) ? 3 : 5; endfunction

  function automatic logic [31:0] d_score(int s, int h);
    return (s == 0) ? 32'(score_a[4*h +: 4]) : 32'(score_b[4*h +: 4]);
  endfunction
  function automatic logic [31:0] d_cnt(int s, int h);
    return (s == 0) ? 32'(cnt_a[2*h +: 2]) : 32'(cnt_b[3*h +: 3]);
  endfunction
  function automatic logic [31:0] d_nat(int s, int h);
    return (s == 0) ? 32'(nat_a[h]) : 32'(nat_b[h]);
  endfunction
  function automatic logic [31:0] d_rv(int s);  return (s == 0) ? 32'(rv_a) : 32'(rv_b); endfunction
  function automatic logic [31:0] d_win(int s); return (s == 0) ? 32'(win_a) : 32'(win_b); endfunction
  function automatic logic [31:0] d_tie(int s); return (s == 0) ? 32'(tie_a) : 32'(tie_b); endfunction
  function automatic logic [31:0] d_rdy(int s);
    return (s == 0) ? 32'(if_a.card_ready) : 32'(if_b.card_ready);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic model_clear(int s);
    for (int h = 0; h < 4; h++) begin
      m_score[s][h] = 0;
      m_cnt[s][h]   = 0;
    end
    m_phase[s] = 0;
  endtask

  task automatic push_result(int s);
    res_t e;
    int   mx = 0;
    int   n  = 0;
    for (int h = 0; h < nh(s); h++) if (m_score[s][h] > mx) mx = m_score[s][h];
    e.winner = -1;
    for (int h = 0; h < nh(s); h++) begin
      if (m_score[s][h] == mx) begin
        n++;
        if (e.winner < 0) e.winner = h;
      end
    end
    e.tie = (n >= 2) ? 1 : 0;
    if (s == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic check_state(int s);
    for (int h = 0; h < nh(s); h++) begin
      check($sformatf("score s%0d h%0d", s, h), d_score(s, h), m_score[s][h]);
      check($sformatf("count s%0d h%0d", s, h), d_cnt(s, h), m_cnt[s][h]);
      check($sformatf("natural s%0d h%0d", s, h), d_nat(s, h),
            (m_cnt[s][h] == 2 && m_score[s][h] >= 8) ? 1 : 0);
    end
    check($sformatf("result_valid s%0d", s), d_rv(s), (m_phase[s] == 2) ? 1 : 0);
    if (m_phase[s] != 2) begin
      check($sformatf("winner idle s%0d", s), d_win(s), 0);
      check($sformatf("tie idle s%0d", s), d_tie(s), 0);
    end
  endtask

  task automatic drive(int s, bit v, int h, int val, bit f, bit c, bit r);
    if_a.card_valid = 1'b0; if_a.card_hand = '0; if_a.card_value = '0;
    if_b.card_valid = 1'b0; if_b.card_hand = '0; if_b.card_value = '0;
    {fin_a, clr_a, rst_a, fin_b, clr_b, rst_b} = '0;
    if (s == 0) begin
      if_a.card_valid = v; if_a.card_hand = 1'(h); if_a.card_value = 4'(val);
      fin_a = f; clr_a = c; rst_a = r;
    end else begin
      if_b.card_valid = v; if_b.card_hand = 2'(h); if_b.card_value = 4'(val);
      fin_b = f; clr_b = c; rst_b = r;
    end
  endtask

  // One clock of stimulus on configuration s; called at a falling edge.
  task automatic step(int s, bit v, int h, int val, bit f, bit c, bit r);
    bit exp_rdy;
    drive(s, v, h, val, f, c, r);
    #1;
    exp_rdy = (m_phase[s] == 0) && !c && !r && (h < nh(s)) && (m_cnt[s][h] < mc(s));
    check($sformatf("card_ready s%0d h%0d", s, h), d_rdy(s), 32'(exp_rdy));
    @(posedge clk);
    if (r || c) begin
      model_clear(s);
    end else begin
      if (v && exp_rdy) begin
        m_score[s][h] = (m_score[s][h] + ((val >= 10) ? 0 : val)) % 10;
        m_cnt[s][h]++;
      end
      if (m_phase[s] == 1) m_phase[s] = 2;
      else if (m_phase[s] == 0 && f) begin
        push_result(s);
        m_phase[s] = 1;
      end
    end
    @(negedge clk);
    check_state(s);
  endtask

  task automatic idle(int s); step(s, 0, 0, 0, 0, 0, 0); endtask
  task automatic card(int s, int h, int v); step(s, 1, h, v, 0, 0, 0); endtask

  // Scoreboard monitor: each new result_valid consumes one expected round result.
  logic prv_a = 1'b0;
  logic prv_b = 1'b0;
  always @(negedge clk) begin
    res_t e;
    if (rv_a === 1'b1 && prv_a !== 1'b1) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL result s0: result_valid=1 with no finalize pending");
      end else begin
        e = q_a.pop_front();
        check("winner s0", 32'(win_a), e.winner);
        check("tie s0", 32'(tie_a), e.tie);
      end
    end
    if (rv_b === 1'b1 && prv_b !== 1'b1) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL result s1: result_valid=1 with no finalize pending");
      end else begin
        e = q_b.pop_front();
        check("winner s1", 32'(win_b), e.winner);
        check("tie s1", 32'(tie_b), e.tie);
      end
    end
    prv_a = rv_a;
    prv_b = rv_b;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 1);
    rst_b = 1'b1;
    model_clear(0);
    model_clear(1);
    @(negedge clk);
    @(negedge clk);
    check_state(0);
    check_state(1);

    // Cards (h0,7),(h1,12),(h0,5),(h1,9)
    card(0, 0, 7); card(0, 1, 12); card(0, 0, 5); card(0, 1, 9);
    check("t1 score0", d_score(0, 0), 2);
    check("t1 score1", d_score(0, 1), 9);
    check("t1 natural", 32'(nat_a), 2);

    // Resolve; cards and finalize in DONE are refused
    step(0, 0, 0, 0, 1, 0, 0);
    idle(0);
    check("t2 winner", 32'(win_a), 1);
    step(0, 1, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    // Full hand refuses a fourth card, the other hand still accepts
    step(0, 0, 0, 0, 0, 1, 0);
    card(0, 0, 9); card(0, 0, 9); card(0, 0, 9);
    check("t3 score0", d_score(0, 0), 7);
    card(0, 0, 4);
    card(0, 1, 4);

    // Tied sixes, then finalize with no cards
    step(0, 0, 0, 0, 0, 1, 0);
    card(0, 0, 6); card(0, 1, 6);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(0); idle(0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(0); idle(0);

    // clear beats a card; finalize with a card includes it
    step(0, 1, 0, 5, 0, 1, 0);
    card(0, 0, 5);
    step(0, 1, 1, 3, 1, 0, 0);
    idle(0); idle(0);

    // Reset in DONE and mid-deal
    step(0, 0, 0, 0, 0, 0, 1);
    card(0, 0, 4); card(0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(0);

    // Randomized rounds on both configurations
    for (int s = 0; s < 2; s++) begin
      step(s, 0, 0, 0, 0, 0, 1);
      for (int round = 0; round < 30; round++) begin
        int n = $urandom_range(0, 22);
        step(s, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < n; k++) begin
          int rr = $urandom_range(0, 99);
          step(s, $urandom_range(0, 3) != 0, $urandom_range(0, nh(s) - 1),
               $urandom_range(0, 15), 1'b0, rr == 0, rr == 1);
        end
        step(s, $urandom_range(0, 1) != 0, $urandom_range(0, nh(s) - 1),
             $urandom_range(0, 15), 1'b1, 1'b0, 1'b0);
        idle(s); idle(s);
      end
    end

    idle(0);
    check("pending results s0", q_a.size(), 0);
    check("pending results s1", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
